nf_axis_pkt_arbiter: RTL and testbench
======================================

NF_AXIS_PKT_ARBITER -- requirements
Module: nf_axis_pkt_arbiter

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 512, SHALL set the TDATA width of all streams; the TKEEP width is C_AXIS_DATA_WIDTH/8.
REQ-002 Parameter C_AXIS_TUSER_WIDTH, default 128, SHALL set the TUSER width of all streams.
REQ-003 ACLK  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 ARESETN  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 S0_AXIS_TDATA/TKEEP/TUSER/TLAST/TVALID  in  W/W/8/TU/1/1  SHALL be requester-0 stream input, packet-framed by TLAST.
REQ-006 S0_AXIS_TREADY  out  1  SHALL be requester-0 backpressure.
REQ-007 S1_AXIS_TDATA/TKEEP/TUSER/TLAST/TVALID  in  same widths as S0  SHALL be requester-1 stream input.
REQ-008 S1_AXIS_TREADY  out  1  SHALL be requester-1 backpressure.
REQ-009 M_AXIS_TDATA/TKEEP/TUSER/TLAST/TVALID  out  same widths as S0  SHALL be the shared stream toward the le_be bridge input.
REQ-010 M_AXIS_TREADY  in  1  SHALL be downstream backpressure.
REQ-011 GRANT  out  2  SHALL be one-hot owner (bit0 = S0, bit1 = S1); it is 00 when idle.
REQ-012 PKT_CNT0, PKT_CNT1  out  32 each  SHALL count packets forwarded from S0 and S1.

Function
REQ-013 The FSM SHALL have the states IDLE, PKT0 and PKT1; GRANT = 00/01/10 respectively.
REQ-014 In IDLE, if S0_TVALID and (!S1_TVALID or last_grant==1), the FSM SHALL go to PKT0; else if S1_TVALID, to PKT1; else it stays in IDLE.
REQ-015 In IDLE, both S*_TREADY SHALL be 0; no beat is accepted in the arbitration cycle (one-cycle bubble per packet).
REQ-016 out_ready SHALL be defined as !M_AXIS_TVALID or M_AXIS_TREADY.
REQ-017 In PKTn, S{n}_TREADY SHALL equal out_ready, and the non-granted TREADY SHALL be 0.
REQ-018 A beat SHALL be accepted when the granted TVALID and TREADY are both 1; TDATA/TKEEP/TUSER/TLAST SHALL be registered into the output stage on that edge, with M_AXIS_TVALID set.
REQ-019 M_AXIS_TVALID SHALL clear when M_AXIS_TREADY=1 and no new beat is loaded in the same cycle.
REQ-020 Latency SHALL be exactly 1 cycle from input acceptance to M_AXIS_TVALID; throughput SHALL be 1 beat/cycle within a packet under continuous TREADY.
REQ-021 M_AXIS payload SHALL hold stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
REQ-022 An accepted beat with TLAST=1 in PKTn SHALL set last_grant to n, increment PKT_CNTn, and return the FSM to IDLE on that edge.
REQ-023 Grant SHALL never change mid-packet, regardless of the other requester's TVALID.
REQ-024 PKT_CNT0/1 SHALL wrap from 0xFFFFFFFF to 0 without saturation or flag.
REQ-025 A single-beat packet (TLAST on the first beat) SHALL occupy exactly 2 arbitration+transfer cycles with no stall.
REQ-026 Input TVALID deasserting mid-packet SHALL hold the grant; M_AXIS_TVALID drains and the FSM waits in PKTn.
REQ-027 TKEEP and TUSER SHALL be passed unmodified; the block performs no byte reordering.

Reset
REQ-028 While ARESETN=0, the block SHALL hold: FSM=IDLE, last_grant=1 (S0 first), M_AXIS_TVALID=0, M_AXIS_TDATA/TKEEP/TUSER/TLAST=0, S0/S1_TREADY=0, GRANT=00, PKT_CNT0/1=0.
REQ-029 A reset asserted mid-packet SHALL discard the partial packet immediately (asynchronously); no recovery of the truncated packet is required.
REQ-030 After ARESETN deasserts, the first arbitration SHALL occur on the first ACLK edge with a valid request.

Verification
REQ-031 Scenario: S0 and S1 each present a 3-beat packet simultaneously after reset -> S0 packet is forwarded first (beats at cycles 2-4), then S1 after a 1-cycle IDLE; PKT_CNT0=1, PKT_CNT1=1.
REQ-032 Scenario: both requesters continuously offer 1-beat packets for 8 packets -> strict alternation S0,S1,S0,... on M_AXIS_TUSER tags; 4 packets each.
REQ-033 Scenario: M_AXIS_TREADY=0 for 5 cycles mid-packet -> M_AXIS payload is stable, granted TREADY=0 after the output register fills, no beat is lost or duplicated.
REQ-034 Scenario: S1 asserts TVALID while S0 is mid-packet -> GRANT stays 01 until S0 TLAST is accepted, then becomes 10.
REQ-035 Scenario: ARESETN is pulsed low during beat 2 of a 4-beat packet -> all outputs are 0 within the reset window, counters are 0, and the next packet is forwarded cleanly.
REQ-036 Scenario: PKT_CNT0 is preloaded via force to 0xFFFFFFFF and one S0 packet is sent -> PKT_CNT0 = 0.

Source files
------------

// File: rtl/nf_axis_pkt_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// nf_axis_pkt_arbiter : two-requester packet-level AXI-Stream arbiter with a
// one-beat registered output stage. Revision: 1.0
// -----------------------------------------------------------------------------
module nf_axis_pkt_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            i_aclk,
  input  logic                            i_aresetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    i_s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  i_s0_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   i_s0_axis_tuser,
  input  logic                            i_s0_axis_tlast,
  input  logic                            i_s0_axis_tvalid,
  output logic                            o_s0_axis_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    i_s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  i_s1_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   i_s1_axis_tuser,
  input  logic                            i_s1_axis_tlast,
  input  logic                            i_s1_axis_tvalid,
  output logic                            o_s1_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    o_m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  o_m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   o_m_axis_tuser,
  output logic                            o_m_axis_tlast,
  output logic                            o_m_axis_tvalid,
  input  logic                            i_m_axis_tready,

  output logic [1:0]                      o_grant,
  output logic [31:0]                     o_pkt_cnt0,
  output logic [31:0]                     o_pkt_cnt1
);

  // State encoding doubles as the one-hot GRANT value.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PKT0 = 2'b01;
  localparam logic [1:0] S_PKT1 = 2'b10;

  logic [1:0]                     r_state;
  logic                           r_last_grant;
  logic                           r_m_tvalid;
  logic [C_AXIS_DATA_WIDTH-1:0]   r_m_tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0] r_m_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]  r_m_tuser;
  logic                           r_m_tlast;
  logic [31:0]                    r_pkt_cnt0;
  logic [31:0]                    r_pkt_cnt1;

  logic w_out_ready;
  logic w_s0_tready;
  logic w_s1_tready;
  logic w_acc0;
  logic w_acc1;
  logic w_accept;

  assign w_out_ready = !r_m_tvalid || i_m_axis_tready;
  assign w_s0_tready = (r_state == S_PKT0) && w_out_ready;
  assign w_s1_tready = (r_state == S_PKT1) && w_out_ready;
  assign w_acc0      = w_s0_tready && i_s0_axis_tvalid;
  assign w_acc1      = w_s1_tready && i_s1_axis_tvalid;
  assign w_accept    = w_acc0 || w_acc1;

  // r_last_grant = 1 means S1 was served last, so S0 wins the next tie.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_s0_axis_tvalid && (!i_s1_axis_tvalid || r_last_grant)) begin
            r_state <= S_PKT0;
          end else if (i_s1_axis_tvalid) begin
            r_state <= S_PKT1;
          end
        end
        S_PKT0: begin
          if (w_acc0 && i_s0_axis_tlast) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b0;
          end
        end
        S_PKT1: begin
          if (w_acc1 && i_s1_axis_tlast) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_acc1 ? i_s1_axis_tdata : i_s0_axis_tdata;
      r_m_tkeep  <= w_acc1 ? i_s1_axis_tkeep : i_s0_axis_tkeep;
      r_m_tuser  <= w_acc1 ? i_s1_axis_tuser : i_s0_axis_tuser;
      r_m_tlast  <= w_acc1 ? i_s1_axis_tlast : i_s0_axis_tlast;
    end else if (i_m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_pkt_cnt0 <= 32'd0;
      r_pkt_cnt1 <= 32'd0;
    end else begin
      if (w_acc0 && i_s0_axis_tlast) r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
      if (w_acc1 && i_s1_axis_tlast) r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
    end
  end

  assign o_s0_axis_tready = w_s0_tready;
  assign o_s1_axis_tready = w_s1_tready;
  assign o_m_axis_tvalid  = r_m_tvalid;
  assign o_m_axis_tdata   = r_m_tdata;
  assign o_m_axis_tkeep   = r_m_tkeep;
  assign o_m_axis_tuser   = r_m_tuser;
  assign o_m_axis_tlast   = r_m_tlast;
  assign o_grant          = r_state;
  assign o_pkt_cnt0       = r_pkt_cnt0;
  assign o_pkt_cnt1       = r_pkt_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_nf_axis_pkt_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_nf_axis_pkt_arbiter : directed vectors plus randomized traffic against a
// behavioural packet-arbitration model. Revision: 1.0
// -----------------------------------------------------------------------------
module tb_nf_axis_pkt_arbiter;
  localparam int DW = 32;
  localparam int TU = 8;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic [TU-1:0] s0_tuser, s1_tuser, m_tuser;
  logic s0_tlast, s0_tvalid, s0_tready;
  logic s1_tlast, s1_tvalid, s1_tready;
  logic m_tlast, m_tvalid, m_tready;
  logic [1:0]  grant;
  logic [31:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] outq[$];
  int         outcyc[$];

  always #5 clk = ~clk;

  nf_axis_pkt_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TU)) dut (
    .i_aclk(clk), .i_aresetn(rst_n),
    .i_s0_axis_tdata(s0_tdata), .i_s0_axis_tkeep(s0_tkeep), .i_s0_axis_tuser(s0_tuser),
    .i_s0_axis_tlast(s0_tlast), .i_s0_axis_tvalid(s0_tvalid), .o_s0_axis_tready(s0_tready),
    .i_s1_axis_tdata(s1_tdata), .i_s1_axis_tkeep(s1_tkeep), .i_s1_axis_tuser(s1_tuser),
    .i_s1_axis_tlast(s1_tlast), .i_s1_axis_tvalid(s1_tvalid), .o_s1_axis_tready(s1_tready),
    .o_m_axis_tdata(m_tdata), .o_m_axis_tkeep(m_tkeep), .o_m_axis_tuser(m_tuser),
    .o_m_axis_tlast(m_tlast), .o_m_axis_tvalid(m_tvalid), .i_m_axis_tready(m_tready),
    .o_grant(grant), .o_pkt_cnt0(cnt0), .o_pkt_cnt1(cnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tagged beat: data and keep are derived from the tag so payload can be checked.
  task automatic drive(input int n, input logic v, input logic [7:0] u, input logic l);
    if (n == 0) begin
      s0_tvalid = v; s0_tuser = u; s0_tdata = {4{u}}; s0_tkeep = u[3:0]; s0_tlast = l;
    end else begin
      s1_tvalid = v; s1_tuser = u; s1_tdata = {4{u}}; s1_tkeep = u[3:0]; s1_tlast = l;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_mdata"},  64'(m_tdata),  64'd0);
    chk({tag, "_mkeep"},  64'(m_tkeep),  64'd0);
    chk({tag, "_muser"},  64'(m_tuser),  64'd0);
    chk({tag, "_mlast"},  64'(m_tlast),  64'd0);
    chk({tag, "_rdy0"},   64'(s0_tready), 64'd0);
    chk({tag, "_rdy1"},   64'(s1_tready), 64'd0);
    chk({tag, "_grant"},  64'(grant), 64'd0);
    chk({tag, "_cnt0"},   64'(cnt0), 64'd0);
    chk({tag, "_cnt1"},   64'(cnt1), 64'd0);
  endtask

  task automatic xfer(input int n, input logic [7:0] base, input int len);
    int idx = 0;
    int cyc = 0;
    outq.delete();
    m_tready = 1'b1;
    drive(1 - n, 1'b0, 8'h00, 1'b0);
    while ((idx < len || m_tvalid) && cyc < 30) begin
      @(negedge clk);
      drive(n, idx < len, 8'(base + 8'(idx)), idx == len - 1);
      #1;
      if (m_tvalid && m_tready) outq.push_back(m_tuser);
      if ((n == 0 ? s0_tready : s1_tready) && idx < len) idx++;
      cyc++;
    end
    drive(n, 1'b0, 8'h00, 1'b0);
    chk("xfer_in_budget", 64'(cyc < 30), 64'd1);
    chk("xfer_beats", 64'(outq.size()), 64'(len));
    for (int i = 0; i < outq.size() && i < len; i++)
      chk("xfer_order", 64'(outq[i]), 64'(8'(base + 8'(i))));
  endtask

  typedef struct {
    logic v0; logic [7:0] u0; logic l0;
    logic v1; logic [7:0] u1; logic l1;
    logic mr;
    logic [1:0] g; logic r0; logic r1; logic mv; logic [7:0] mu;
  } vec_t;

  vec_t tbl[10];

  // Behavioural model state for the random phase.
  int         owner, lastg;
  logic       mv, ml;
  logic [31:0] md;
  logic [3:0]  mk;
  logic [7:0]  mu;
  logic [31:0] ecnt[2];
  logic        sv[2], sl[2];
  logic [31:0] sd[2];
  logic [3:0]  sk[2];
  logic [7:0]  su[2];
  int          rem[2];

  initial begin
    int idx;
    // both requesters present 3-beat packets; S1 keeps requesting while S0 is mid-packet
    tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h01};
    tbl[3] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h02};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 8'h03};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h13, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h12};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 8'h13};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset holds everything at zero even with requests pending.
    drive(0, 1'b1, 8'hAA, 1'b1);
    drive(1, 1'b1, 8'hBB, 1'b1);
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_all_zero("reset");
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(0, tbl[i].v0, tbl[i].u0, tbl[i].l0);
      drive(1, tbl[i].v1, tbl[i].u1, tbl[i].l1);
      m_tready = tbl[i].mr;
      #1;
      chk("tbl_grant", 64'(grant), 64'(tbl[i].g));
      chk("tbl_rdy0", 64'(s0_tready), 64'(tbl[i].r0));
      chk("tbl_rdy1", 64'(s1_tready), 64'(tbl[i].r1));
      chk("tbl_mvalid", 64'(m_tvalid), 64'(tbl[i].mv));
      if (tbl[i].mv) begin
        chk("tbl_muser", 64'(m_tuser), 64'(tbl[i].mu));
        chk("tbl_mdata", 64'(m_tdata), 64'({4{tbl[i].mu}}));
        chk("tbl_mkeep", 64'(m_tkeep), 64'(tbl[i].mu[3:0]));
        chk("tbl_mlast", 64'(m_tlast), 64'(tbl[i].mu == 8'h03 || tbl[i].mu == 8'h13));
      end
    end
    chk("tbl_cnt0", 64'(cnt0), 64'd1);
    chk("tbl_cnt1", 64'(cnt1), 64'd1);

    // Five-cycle downstream stall in the middle of a 4-beat S0 packet.
    outq.delete();
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      m_tready = !(k >= 3 && k <= 7);
      drive(0, idx < 4, 8'(8'h41 + 8'(idx)), idx == 3);
      drive(1, 1'b0, 8'h00, 1'b0);
      #1;
      if (k >= 3 && k <= 7) begin
        chk("stall_mvalid", 64'(m_tvalid), 64'd1);
        chk("stall_muser", 64'(m_tuser), 64'h42);
        chk("stall_mdata", 64'(m_tdata), 64'h42424242);
        chk("stall_rdy0", 64'(s0_tready), 64'd0);
      end
      if (m_tvalid && m_tready) outq.push_back(m_tuser);
      if (s0_tready && idx < 4) idx++;
    end
    chk("stall_beats", 64'(outq.size()), 64'd4);
    for (int i = 0; i < outq.size() && i < 4; i++)
      chk("stall_order", 64'(outq[i]), 64'(8'(8'h41 + 8'(i))));
    chk("stall_cnt0", 64'(cnt0), 64'd2);

    // Asynchronous reset while beat 2 of a 4-beat packet is being offered.
    m_tready = 1'b1;
    idx = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1'b1, 8'(8'h51 + 8'(idx)), 1'b0);
      #1;
      if (s0_tready) idx++;
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;

    // Both sides offering single-beat packets: strict alternation, 2 cycles each.
    begin
      int k0 = 0;
      int k1 = 0;
      int cyc = 0;
      outq.delete();
      outcyc.delete();
      while (outq.size() < 8 && cyc < 40) begin
        @(negedge clk);
        drive(0, k0 < 4, 8'(8'h20 + 8'(k0)), 1'b1);
        drive(1, k1 < 4, 8'(8'h30 + 8'(k1)), 1'b1);
        #1;
        if (m_tvalid && m_tready) begin
          outq.push_back(m_tuser);
          outcyc.push_back(cyc);
        end
        if (s0_tready && s0_tvalid) k0++;
        if (s1_tready && s1_tvalid) k1++;
        cyc++;
      end
      drive(0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 1'b0);
      chk("alt_count", 64'(outq.size()), 64'd8);
      for (int i = 0; i < outq.size(); i++)
        chk("alt_tag", 64'(outq[i]), 64'(8'(((i % 2) == 0 ? 8'h20 : 8'h30) + 8'(i / 2))));
      if (outcyc.size() == 8) chk("alt_last_cycle", 64'(outcyc[7]), 64'd16);
      @(negedge clk);
      chk("alt_cnt0", 64'(cnt0), 64'd4);
      chk("alt_cnt1", 64'(cnt1), 64'd4);
    end

    // Counter wrap.
    @(negedge clk);
    force dut.r_pkt_cnt0 = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_cnt0;
    #1;
    chk("wrap_preload", 64'(cnt0), 64'hFFFF_FFFF);
    xfer(0, 8'h70, 2);
    chk("wrap_cnt0", 64'(cnt0), 64'd0);
    chk("wrap_cnt1", 64'(cnt1), 64'd4);

    // Randomized traffic against the behavioural model.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    owner = -1; lastg = 1; mv = 1'b0;
    md = '0; mk = '0; mu = '0; ml = 1'b0;
    for (int n = 0; n < 2; n++) begin
      ecnt[n] = '0; sv[n] = 1'b0; sl[n] = 1'b0; sd[n] = '0; sk[n] = '0; su[n] = '0; rem[n] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      int  acc;
      int  was_idle;
      logic ordy;
      logic [1:0] eg;
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!sv[n] && $urandom_range(0, 99) < 60) begin
          if (rem[n] == 0) rem[n] = $urandom_range(1, 4);
          sv[n] = 1'b1;
          sd[n] = $urandom;
          sk[n] = 4'($urandom);
          su[n] = 8'($urandom);
          sl[n] = (rem[n] == 1);
        end
      end
      s0_tvalid = sv[0]; s0_tdata = sd[0]; s0_tkeep = sk[0]; s0_tuser = su[0]; s0_tlast = sl[0];
      s1_tvalid = sv[1]; s1_tdata = sd[1]; s1_tkeep = sk[1]; s1_tuser = su[1]; s1_tlast = sl[1];
      m_tready = ($urandom_range(0, 99) < 70);
      #1;
      ordy = !mv || m_tready;
      eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      chk("rnd_grant", 64'(grant), 64'(eg));
      chk("rnd_rdy0", 64'(s0_tready), 64'(owner == 0 && ordy));
      chk("rnd_rdy1", 64'(s1_tready), 64'(owner == 1 && ordy));
      chk("rnd_mvalid", 64'(m_tvalid), 64'(mv));
      if (mv) begin
        chk("rnd_mdata", 64'(m_tdata), 64'(md));
        chk("rnd_mkeep", 64'(m_tkeep), 64'(mk));
        chk("rnd_muser", 64'(m_tuser), 64'(mu));
        chk("rnd_mlast", 64'(m_tlast), 64'(ml));
      end
      chk("rnd_cnt0", 64'(cnt0), 64'(ecnt[0]));
      chk("rnd_cnt1", 64'(cnt1), 64'(ecnt[1]));

      acc = -1;
      was_idle = (owner == -1);
      if (!was_idle && sv[owner] && ordy) acc = owner;
      if (acc >= 0) begin
        mv = 1'b1; md = sd[acc]; mk = sk[acc]; mu = su[acc]; ml = sl[acc];
        sv[acc] = 1'b0;
        rem[acc]--;
        if (sl[acc]) begin
          ecnt[acc] = ecnt[acc] + 32'd1;
          lastg = acc;
          owner = -1;
        end
      end else if (m_tready) begin
        mv = 1'b0;
      end
      if (was_idle) begin
        if (sv[0] && (!sv[1] || lastg == 1)) owner = 0;
        else if (sv[1]) owner = 1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
